escritor_registros: RTL and testbench

- Configuration initiator for the filter datapath: drives the register-write bus (direccion_registros / datos_registros / habilitacion_registros) that control_mascara and sibling control blocks consume.
- On a start pulse, reads a programmable number of (address, data) words from a synchronous config ROM.
- Issues one single-cycle write strobe per word, with a fixed idle gap between writes, then pulses done.

---
 rtl/escritor_registros_pkg.sv | 26 ++
 rtl/escritor_registros_if.sv | 24 ++
 rtl/escritor_registros_contador_pausa.sv | 28 ++
 rtl/escritor_registros.sv | 107 ++++++++++
 tb/tb_escritor_registros.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/escritor_registros_pkg.sv
// Shared constants for the filter-datapath configuration blocks: bus widths,
// config ROM word layout and the register-writer state encoding.
package paquete_filtros;

    localparam int ANCHO_DIR  = 11;
    localparam int ANCHO_DATO = 21;
    localparam int ANCHO_ROM  = 5;
    localparam int PAUSA_DEF  = 2;

    // ROM word layout: register address in the upper bits, register data below it
    localparam int ROM_LSB_DATO = 0;
    localparam int ROM_LSB_DIR  = ANCHO_DATO;

    localparam logic [2:0] EST_REPOSO   = 3'd0;
    localparam logic [2:0] EST_LEER     = 3'd1;
    localparam logic [2:0] EST_ESPERA   = 3'd2;
    localparam logic [2:0] EST_ESCRIBIR = 3'd3;
    localparam logic [2:0] EST_PAUSA    = 3'd4;
    localparam logic [2:0] EST_FIN      = 3'd5;

    // Counter width able to hold ciclos-1; never narrower than one bit
    function automatic int ancho_contador(input int ciclos);
        return (ciclos < 2) ? 1 : $clog2(ciclos);
    endfunction

endpackage

// File: rtl/escritor_registros_if.sv
// Register-write bus shared by the configuration initiator and the control
// blocks it programs (control_mascara and siblings).
interface escritor_registros_if #(
    parameter int ANCHO_DIR  = paquete_filtros::ANCHO_DIR,
    parameter int ANCHO_DATO = paquete_filtros::ANCHO_DATO
);

    logic [ANCHO_DIR-1:0]  direccion_registros;
    logic [ANCHO_DATO-1:0] datos_registros;
    logic                  habilitacion_registros;

    modport master (
        output direccion_registros,
        output datos_registros,
        output habilitacion_registros
    );

    modport slave (
        input direccion_registros,
        input datos_registros,
        input habilitacion_registros
    );

endinterface

// File: rtl/escritor_registros_contador_pausa.sv
// Loadable down-counter with a zero flag; it saturates at zero so an idle
// decrement request is harmless.
module contador_pausa #(
    parameter int ANCHO = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cargar,
    input  logic [ANCHO-1:0] valor,
    input  logic             decrementar,
    output logic             cero
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (decrementar && (cuenta != '0)) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/escritor_registros.sv
// Configuration initiator: on inicio, walks a synchronous config ROM and issues
// one register-write strobe per word, separated by PAUSA idle cycles.
module escritor_registros #(
    parameter int ANCHO_DIR  = paquete_filtros::ANCHO_DIR,
    parameter int ANCHO_DATO = paquete_filtros::ANCHO_DATO,
    parameter int ANCHO_ROM  = paquete_filtros::ANCHO_ROM,
    parameter int PAUSA      = paquete_filtros::PAUSA_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inicio,
    input  logic [ANCHO_ROM:0]            num_escrituras,
    output logic [ANCHO_ROM-1:0]          direccion_rom,
    input  logic [ANCHO_DIR+ANCHO_DATO-1:0] dato_rom,
    output logic                          ocupado,
    output logic                          listo,
    escritor_registros_if.master          bus
);

    import paquete_filtros::*;

    localparam int ANCHO_CNT = ancho_contador(PAUSA);
    localparam logic [ANCHO_CNT-1:0] CARGA_PAUSA = ANCHO_CNT'((PAUSA > 0) ? PAUSA - 1 : 0);
    localparam logic [ANCHO_ROM:0]   UNO = (ANCHO_ROM + 1)'(1);

    logic [2:0]         estado;
    logic [2:0]         estado_sig;
    logic [ANCHO_ROM:0] total;
    logic [ANCHO_ROM:0] indice;
    logic [ANCHO_ROM:0] indice_lectura;
    logic               ultima;
    logic               pausa_cero;

    assign ultima  = ((indice + UNO) == total);
    assign ocupado = (estado != EST_REPOSO);

    // Index presented to the ROM on entry to LEER; ROM address only moves then
    always_comb begin
        indice_lectura = indice;
        if (estado == EST_REPOSO) begin
            indice_lectura = '0;
        end else if (estado == EST_ESCRIBIR) begin
            indice_lectura = indice + UNO;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            EST_REPOSO:   if (inicio) estado_sig = (num_escrituras == '0) ? EST_FIN : EST_LEER;
            EST_LEER:     estado_sig = EST_ESPERA;
            EST_ESPERA:   estado_sig = EST_ESCRIBIR;
            EST_ESCRIBIR: begin
                if (ultima)         estado_sig = EST_FIN;
                else if (PAUSA > 0) estado_sig = EST_PAUSA;
                else                estado_sig = EST_LEER;
            end
            EST_PAUSA:    if (pausa_cero) estado_sig = EST_LEER;
            EST_FIN:      estado_sig = EST_REPOSO;
            default:      estado_sig = EST_REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado                     <= EST_REPOSO;
            total                      <= '0;
            indice                     <= '0;
            direccion_rom              <= '0;
            listo                      <= 1'b0;
            bus.direccion_registros    <= '0;
            bus.datos_registros        <= '0;
            bus.habilitacion_registros <= 1'b0;
        end else begin
            estado                     <= estado_sig;
            listo                      <= (estado_sig == EST_FIN);
            bus.habilitacion_registros <= (estado == EST_ESPERA);
            if ((estado == EST_REPOSO) && inicio) begin
                total  <= num_escrituras;
                indice <= '0;
            end
            if (estado == EST_ESCRIBIR) begin
                indice <= indice + UNO;
            end
            if (estado_sig == EST_LEER) begin
                direccion_rom <= indice_lectura[ANCHO_ROM-1:0];
            end
            // The ROM word read during LEER is valid for the whole ESPERA cycle
            if (estado == EST_ESPERA) begin
                bus.direccion_registros <= dato_rom[ROM_LSB_DIR +: ANCHO_DIR];
                bus.datos_registros     <= dato_rom[ROM_LSB_DATO +: ANCHO_DATO];
            end
        end
    end

    contador_pausa #(
        .ANCHO(ANCHO_CNT)
    ) u_contador_pausa (
        .clk         (clk),
        .reset       (reset),
        .cargar      (estado == EST_ESCRIBIR),
        .valor       (CARGA_PAUSA),
        .decrementar (estado == EST_PAUSA),
        .cero        (pausa_cero)
    );

endmodule

// File: tb/tb_escritor_registros.sv
// Scoreboard bench for escritor_registros: one instance with the default idle
// gap and one with no gap for the full-ROM sweep.
module tb_escritor_registros;

    import paquete_filtros::*;

    typedef struct packed {
        logic [ANCHO_DIR-1:0]  dir;
        logic [ANCHO_DATO-1:0] dato;
    } escritura_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [32];

    logic        inicio_a = 1'b0;
    logic [5:0]  num_a = '0;
    logic [4:0]  dir_rom_a;
    logic [31:0] dato_rom_a = '0;
    logic        ocupado_a;
    logic        listo_a;
    escritor_registros_if bus_a ();

    logic        inicio_b = 1'b0;
    logic [5:0]  num_b = '0;
    logic [4:0]  dir_rom_b;
    logic [31:0] dato_rom_b = '0;
    logic        ocupado_b;
    logic        listo_b;
    escritor_registros_if bus_b ();

    escritor_registros #(.PAUSA(2)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .inicio         (inicio_a),
        .num_escrituras (num_a),
        .direccion_rom  (dir_rom_a),
        .dato_rom       (dato_rom_a),
        .ocupado        (ocupado_a),
        .listo          (listo_a),
        .bus            (bus_a)
    );

    escritor_registros #(.PAUSA(0)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .inicio         (inicio_b),
        .num_escrituras (num_b),
        .direccion_rom  (dir_rom_b),
        .dato_rom       (dato_rom_b),
        .ocupado        (ocupado_b),
        .listo          (listo_b),
        .bus            (bus_b)
    );

    // Synchronous config ROM models, one read port per instance
    always @(posedge clk) begin
        dato_rom_a <= rom[dir_rom_a];
        dato_rom_b <= rom[dir_rom_b];
    end

    int vectors = 0;
    int miscompares = 0;
    int ciclo = 0;
    escritura_t cola_a[$];
    escritura_t cola_b[$];
    escritura_t esp_a;
    escritura_t esp_b;
    int listo_pend_a = 0;
    int listo_pend_b = 0;
    int strobes_b = 0;
    int ultimo_b = -1;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic checkOutput(input string nombre, input logic [31:0] obtenido, input logic [31:0] esperado);
        vectors++;
        if (obtenido !== esperado) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nombre, obtenido, esperado);
        end
    endtask

    function automatic escritura_t palabra(input int i);
        logic [31:0] w;
        w = rom[i];
        return '{dir: w[ROM_LSB_DIR +: ANCHO_DIR], dato: w[ROM_LSB_DATO +: ANCHO_DATO]};
    endfunction

    // Queue the writes a run is expected to produce, then pulse inicio (returns at E0+1)
    task automatic applyStimulus(input logic [5:0] num);
        for (int i = 0; i < int'(num); i++) cola_a.push_back(palabra(i));
        listo_pend_a++;
        @(negedge clk);
        num_a = num;
        inicio_a = 1'b1;
        @(posedge clk);
        #1 inicio_a = 1'b0;
    endtask

    task automatic waitIdleA(input int limite);
        int n;
        n = 0;
        while (ocupado_a && (n < limite)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idleA_timeout", 32'(ocupado_a), 32'd0);
    endtask

    // Monitor for instance A: every strobe and every listo must have been predicted
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_a.habilitacion_registros) begin
                if (cola_a.size() == 0) begin
                    checkOutput("strobeA_unexpected", 32'(cola_a.size()), 32'd1);
                end else begin
                    esp_a = cola_a.pop_front();
                    checkOutput("dirA", 32'(bus_a.direccion_registros), 32'(esp_a.dir));
                    checkOutput("datoA", 32'(bus_a.datos_registros), 32'(esp_a.dato));
                end
            end
            if (listo_a) begin
                if (listo_pend_a == 0) checkOutput("listoA_unexpected", 32'(listo_pend_a), 32'd1);
                else listo_pend_a--;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_b.habilitacion_registros) begin
                strobes_b++;
                if (ultimo_b >= 0) checkOutput("spacingB", 32'(ciclo - ultimo_b), 32'd3);
                ultimo_b = ciclo;
                if (cola_b.size() == 0) begin
                    checkOutput("strobeB_unexpected", 32'(cola_b.size()), 32'd1);
                end else begin
                    esp_b = cola_b.pop_front();
                    checkOutput("dirB", 32'(bus_b.direccion_registros), 32'(esp_b.dir));
                    checkOutput("datoB", 32'(bus_b.datos_registros), 32'(esp_b.dato));
                end
            end
            if (listo_b) begin
                if (listo_pend_b == 0) checkOutput("listoB_unexpected", 32'(listo_pend_b), 32'd1);
                else listo_pend_b--;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rom[0] = {11'd0, 21'd3};
        rom[1] = {11'd1, 21'd10};
        for (int i = 2; i < 32; i++) rom[i] = {11'(i * 16 + 5), 21'(i * 1000 + 7)};

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_strobe", 32'(bus_a.habilitacion_registros), 32'd0);
        checkOutput("rst_dir", 32'(bus_a.direccion_registros), 32'd0);
        checkOutput("rst_dato", 32'(bus_a.datos_registros), 32'd0);
        checkOutput("rst_dir_rom", 32'(dir_rom_a), 32'd0);
        checkOutput("rst_listo", 32'(listo_a), 32'd0);
        checkOutput("rst_ocupado", 32'(ocupado_a), 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_strobe_%0d", k), 32'(bus_a.habilitacion_registros), 32'd0);
            checkOutput($sformatf("idle_ocupado_%0d", k), 32'(ocupado_a), 32'd0);
            checkOutput($sformatf("idle_listo_%0d", k), 32'(listo_a), 32'd0);
        end

        // Two-word run with PAUSA=2: strobes at E2 and E7, listo at E8
        applyStimulus(6'd2);
        checkOutput("two_ocupado_E0", 32'(ocupado_a), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("two_strobe_E%0d", k), 32'(bus_a.habilitacion_registros), 32'((k == 2) || (k == 7)));
            checkOutput($sformatf("two_listo_E%0d", k), 32'(listo_a), 32'(k == 8));
            checkOutput($sformatf("two_ocupado_E%0d", k), 32'(ocupado_a), 32'(k <= 8));
        end
        checkOutput("two_queue_empty", 32'(cola_a.size()), 32'd0);
        checkOutput("two_listo_seen", 32'(listo_pend_a), 32'd0);

        // Zero-length run: immediate listo, register bus untouched
        applyStimulus(6'd0);
        checkOutput("zero_listo_E0", 32'(listo_a), 32'd1);
        checkOutput("zero_strobe_E0", 32'(bus_a.habilitacion_registros), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("zero_listo_E1", 32'(listo_a), 32'd0);
        checkOutput("zero_ocupado_E1", 32'(ocupado_a), 32'd0);
        checkOutput("zero_dir_held", 32'(bus_a.direccion_registros), 32'd1);
        checkOutput("zero_dato_held", 32'(bus_a.datos_registros), 32'd10);

        // inicio re-pulsed (and num changed) while busy must be ignored
        applyStimulus(6'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        inicio_a = 1'b1;
        num_a = 6'd5;
        repeat (4) @(posedge clk);
        #1 inicio_a = 1'b0;
        waitIdleA(50);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("repulse_no_restart", 32'(ocupado_a), 32'd0);
        checkOutput("repulse_queue_empty", 32'(cola_a.size()), 32'd0);
        checkOutput("repulse_listo_once", 32'(listo_pend_a), 32'd0);

        // Reset while word 1 of 3 is being strobed
        applyStimulus(6'd3);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("midrst_strobe_before", 32'(bus_a.habilitacion_registros), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_strobe", 32'(bus_a.habilitacion_registros), 32'd0);
        checkOutput("midrst_dir", 32'(bus_a.direccion_registros), 32'd0);
        checkOutput("midrst_dato", 32'(bus_a.datos_registros), 32'd0);
        checkOutput("midrst_listo", 32'(listo_a), 32'd0);
        checkOutput("midrst_ocupado", 32'(ocupado_a), 32'd0);
        cola_a.delete();
        listo_pend_a = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midrst_dir_rom", 32'(dir_rom_a), 32'd0);
        applyStimulus(6'd1);
        waitIdleA(50);
        checkOutput("restart_dir", 32'(bus_a.direccion_registros), 32'd0);
        checkOutput("restart_dato", 32'(bus_a.datos_registros), 32'd3);
        checkOutput("restart_queue_empty", 32'(cola_a.size()), 32'd0);
        checkOutput("restart_listo_seen", 32'(listo_pend_a), 32'd0);

        // Full ROM sweep on the zero-gap instance
        for (int i = 0; i < 32; i++) cola_b.push_back(palabra(i));
        listo_pend_b++;
        @(negedge clk);
        num_b = 6'd32;
        inicio_b = 1'b1;
        @(posedge clk);
        #1 inicio_b = 1'b0;
        n = 0;
        while (ocupado_b && (n < 200)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("full_idle_timeout", 32'(ocupado_b), 32'd0);
        checkOutput("full_strobes", 32'(strobes_b), 32'd32);
        checkOutput("full_queue_empty", 32'(cola_b.size()), 32'd0);
        checkOutput("full_listo_seen", 32'(listo_pend_b), 32'd0);
        checkOutput("full_dir_rom_last", 32'(dir_rom_b), 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
